axi4_lite_master: RTL
=====================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have port aclk, input, 1 bit, clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit, reset; synchronous, active-low.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR; cmd_wdata in DATA; cmd_wstrb in DATA/8.
REQ-006 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1 (echoes the command type); rsp_rdata out DATA; rsp_resp out 2 (AXI response code).
REQ-007 SHALL have AW channel ports: m_axi_awaddr out ADDR; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-008 SHALL have W channel ports: m_axi_wdata out DATA; m_axi_wstrb out DATA/8; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-009 SHALL have B channel ports: m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
REQ-010 SHALL have AR channel ports: m_axi_araddr out ADDR; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-011 SHALL have R channel ports: m_axi_rdata in DATA; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA, RESP; one transaction in flight at a time.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; accept a command on cmd_valid&&cmd_ready and register addr/wdata/wstrb/type.
REQ-014 SHALL transition IDLE->WRITE on acceptance with cmd_write=1, and IDLE->RADDR with cmd_write=0.
REQ-015 SHALL assert awvalid and wvalid from the cycle after acceptance, both driven from registers.
REQ-016 SHALL track AW and W completion independently: deassert awvalid the cycle after awvalid&&awready, and wvalid the cycle after wvalid&&wready; either order or same cycle is legal.
REQ-017 SHALL never deassert awvalid, wvalid or arvalid before its handshake completes, and SHALL keep its payload stable while valid.
REQ-018 SHALL transition WRITE->WRESP in the cycle both handshakes have completed, including when the last one completes in that cycle.
REQ-019 SHALL assert bready only in WRESP; on bvalid&&bready SHALL capture bresp into rsp_resp, set rsp_rdata=0, and go to RESP.
REQ-020 SHALL assert arvalid in RADDR; on arvalid&&arready SHALL go to RDATA.
REQ-021 SHALL assert rready only in RDATA; on rvalid&&rready SHALL capture rdata/rresp and go to RESP.
REQ-022 SHALL assert rsp_valid only in RESP, holding rsp_* stable until rsp_valid&&rsp_ready, then return to IDLE.
REQ-023 SHALL accept no new command during the RESP->IDLE cycle (cmd_ready is low in RESP).
REQ-024 SHALL ignore bvalid outside WRESP and rvalid outside RDATA (ready is low there).
REQ-025 SHALL forward non-OKAY responses (SLVERR/DECERR) unchanged and never retry.
REQ-026 SHALL have minimum command-to-rsp_valid latency of 3 cycles when the slave responds with zero wait.

Reset
REQ-027 SHALL, while aresetn=0, set state=IDLE and all valids/readies low (awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready).
REQ-028 SHALL set rsp_rdata, rsp_resp, rsp_write and the AXI payload registers to 0 in reset.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction without generating a response.

Structure
REQ-030 SHALL take response codes (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the FSM state enum from shared package axi_lite_pkg.
REQ-031 SHALL be a single module with no sub-modules.

Verification
REQ-032 Write, zero-wait slave: addr 0x10, data 0xDEADBEEF, strb 0xF -> one AW+W handshake, bready, rsp_resp=00 and rsp_write=1 within 3 cycles.
REQ-033 Write, wready delayed 4 cycles after awready -> awvalid drops after its handshake; wvalid held with stable data; one response.
REQ-034 Read addr 0x20, arready delayed 2 cycles, rdata=0x12345678, rresp=10 -> rsp_rdata=0x12345678, rsp_resp=10.
REQ-035 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready low, no new AXI valid.
REQ-036 Reset in WRESP with bvalid pending -> all outputs 0 next cycle; a subsequent read completes correctly.
REQ-037 Back-to-back write then read commands -> no overlap of AW/W and AR activity; responses in command order.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master transaction FSM states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RESP
  } axi_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI transaction
// and returns one response; every output is registered.
module axi4_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  axi_state_e                  state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic                        aw_done;
  logic                        w_done;

  // A channel counts as done once its valid has dropped or its handshake is this cycle.
  always_comb begin
    aw_done = !m_axi_awvalid || m_axi_awready;
    w_done  = !m_axi_wvalid  || m_axi_wready;
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            addr_q      <= cmd_addr;
            m_axi_wdata <= cmd_wdata;
            m_axi_wstrb <= cmd_wstrb;
            rsp_write   <= cmd_write;
            if (cmd_write) begin
              state         <= ST_WRITE;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= ST_RADDR;
              m_axi_arvalid <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_WRITE: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state        <= ST_WRESP;
            m_axi_bready <= 1'b1;
          end
        end

        ST_WRESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            state        <= ST_RESP;
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
          end
        end

        ST_RADDR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            state         <= ST_RDATA;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end

        ST_RDATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            state        <= ST_RESP;
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
          end
        end

        ST_RESP: begin
          // cmd_ready rises together with the return to IDLE, never during the handshake cycle.
          if (rsp_valid && rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
